// File: rtl/telem_target_reader_if.sv
// Bus bundle between the target readout engine, the target register file and
// the byte sink.
interface telem_target_reader_if;
  logic        req;
  logic        scan_all;
  logic [3:0]  targetSelection;
  logic [15:0] target_valid;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_x;
  logic [7:0]  rd_y;
  logic [7:0]  rd_z;
  logic [7:0]  rd_t;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  modport master (
    output req, scan_all, targetSelection, target_valid,
    output rd_x, rd_y, rd_z, rd_t, tx_ready,
    input  rd_addr, tx_data, tx_valid, busy, done
  );

  modport slave (
    input  req, scan_all, targetSelection, target_valid,
    input  rd_x, rd_y, rd_z, rd_t, tx_ready,
    output rd_addr, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/telem_target_reader.sv
// Reads one target slot (or scans all 16) from the target register file and
// streams it as header/X/Y/Z/T/XOR-checksum byte frames over a valid/ready link.
module telem_target_reader #(
  parameter logic [3:0] HDR_OK    = 4'hA,
  parameter logic [3:0] HDR_EMPTY = 4'hE
) (
  input  logic                 clk,
  input  logic                 rst,
  telem_target_reader_if.slave bus
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LATCH,
    S_HDR,
    S_BX,
    S_BY,
    S_BZ,
    S_BT,
    S_CSUM,
    S_NEXT
  } state_t;

  state_t              r_state;
  logic                r_scan;
  logic                r_valid;
  logic [BYTE_W-1:0]   r_x;
  logic [BYTE_W-1:0]   r_y;
  logic [BYTE_W-1:0]   r_z;
  logic [BYTE_W-1:0]   r_t;
  logic [BYTE_W-1:0]   r_csum;
  logic [IDX_W-1:0]    r_rd_addr;
  logic [BYTE_W-1:0]   r_tx_data;
  logic                r_tx_valid;
  logic                r_busy;
  logic                r_done;

  logic                w_hs;
  logic                w_slot_valid;
  logic                w_last;

  assign w_hs         = r_tx_valid & bus.tx_ready;
  assign w_slot_valid = bus.target_valid[r_rd_addr];
  assign w_last       = (r_rd_addr == IDX_W'(15));

  // Sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_scan     <= 1'b0;
      r_valid    <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_t        <= '0;
      r_csum     <= '0;
      r_rd_addr  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_rd_addr <= bus.scan_all ? IDX_W'(0) : bus.targetSelection;
            r_scan    <= bus.scan_all;
            r_busy    <= 1'b1;
            r_state   <= S_LATCH;
          end
        end

        // Snapshot the slot so table writes during the frame cannot leak in.
        S_LATCH: begin
          r_x     <= bus.rd_x;
          r_y     <= bus.rd_y;
          r_z     <= bus.rd_z;
          r_t     <= bus.rd_t;
          r_valid <= w_slot_valid;
          if (w_slot_valid) begin
            r_tx_data  <= {HDR_OK, r_rd_addr};
            r_csum     <= {HDR_OK, r_rd_addr};
            r_tx_valid <= 1'b1;
            r_state    <= S_HDR;
          end else if (!r_scan) begin
            r_tx_data  <= {HDR_EMPTY, r_rd_addr};
            r_csum     <= {HDR_EMPTY, r_rd_addr};
            r_tx_valid <= 1'b1;
            r_state    <= S_HDR;
          end else begin
            r_state <= S_NEXT;
          end
        end

        // Empty-slot frames jump straight to the checksum (equal to the header).
        S_HDR: begin
          if (w_hs) begin
            if (r_valid) begin
              r_tx_data <= r_x;
              r_csum    <= r_csum ^ r_x;
              r_state   <= S_BX;
            end else begin
              r_tx_data <= r_csum;
              r_state   <= S_CSUM;
            end
          end
        end

        S_BX: begin
          if (w_hs) begin
            r_tx_data <= r_y;
            r_csum    <= r_csum ^ r_y;
            r_state   <= S_BY;
          end
        end

        S_BY: begin
          if (w_hs) begin
            r_tx_data <= r_z;
            r_csum    <= r_csum ^ r_z;
            r_state   <= S_BZ;
          end
        end

        S_BZ: begin
          if (w_hs) begin
            r_tx_data <= r_t;
            r_csum    <= r_csum ^ r_t;
            r_state   <= S_BT;
          end
        end

        S_BT: begin
          if (w_hs) begin
            r_tx_data <= r_csum;
            r_state   <= S_CSUM;
          end
        end

        S_CSUM: begin
          if (w_hs) begin
            r_tx_valid <= 1'b0;
            if (r_scan) begin
              r_state <= S_NEXT;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end

        // Scan advance; the index stops at 15 rather than wrapping.
        S_NEXT: begin
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_rd_addr <= r_rd_addr + IDX_W'(1);
            r_state   <= S_LATCH;
          end
        end

        default: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_addr  = r_rd_addr;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_telem_target_reader.sv
// Scenario bench for telem_target_reader: directed and randomized readouts
// checked against a frame-level reference model of the slot table.
module tb_telem_target_reader;

  localparam logic [3:0] HDR_OK    = 4'hA;
  localparam logic [3:0] HDR_EMPTY = 4'hE;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  telem_target_reader_if ifc();

  telem_target_reader #(.HDR_OK(HDR_OK), .HDR_EMPTY(HDR_EMPTY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  logic [7:0] mem_x [16];
  logic [7:0] mem_y [16];
  logic [7:0] mem_z [16];
  logic [7:0] mem_t [16];

  assign ifc.rd_x = mem_x[ifc.rd_addr];
  assign ifc.rd_y = mem_y[ifc.rd_addr];
  assign ifc.rd_z = mem_z[ifc.rd_addr];
  assign ifc.rd_t = mem_t[ifc.rd_addr];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_mode = 0;
  int req_cyc;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int done_cnt, done_cyc, first_valid_cyc, last_hs_cyc, busy_cnt;
  logic stalled = 1'b0;
  logic [7:0] stall_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink readiness pattern: always, alternating, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ifc.tx_ready = 1'b1;
      1:       ifc.tx_ready = (ifc.tx_ready === 1'b1) ? 1'b0 : 1'b1;
      default: ifc.tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor away from the active edge: collects accepted bytes, checks stall hold.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        n_vec++;
        if (ifc.tx_valid !== 1'b1 || ifc.tx_data !== stall_data) begin
          n_err++;
          $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                   ifc.tx_valid, ifc.tx_data, stall_data);
        end
      end
      if (ifc.tx_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (ifc.tx_valid === 1'b1 && ifc.tx_ready === 1'b1) begin
        obs_q.push_back(ifc.tx_data);
        last_hs_cyc = cyc;
      end
      stalled    = (ifc.tx_valid === 1'b1) && (ifc.tx_ready !== 1'b1);
      stall_data = ifc.tx_data;
      if (ifc.busy === 1'b1) busy_cnt++;
      if (ifc.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Reference model: the byte stream a request should produce from the table.
  task automatic build_exp(input logic scan, input logic [3:0] sel);
    logic [7:0] h;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] idx;
      idx = 4'(i);
      if (scan || idx == sel) begin
        if (ifc.target_valid[idx]) begin
          h = {HDR_OK, idx};
          exp_q.push_back(h);
          exp_q.push_back(mem_x[idx]);
          exp_q.push_back(mem_y[idx]);
          exp_q.push_back(mem_z[idx]);
          exp_q.push_back(mem_t[idx]);
          exp_q.push_back(h ^ mem_x[idx] ^ mem_y[idx] ^ mem_z[idx] ^ mem_t[idx]);
        end else if (!scan) begin
          h = {HDR_EMPTY, idx};
          exp_q.push_back(h);
          exp_q.push_back(h);
        end
      end
    end
  endtask

  task automatic clear_mon();
    obs_q.delete();
    done_cnt        = 0;
    done_cyc        = -1;
    first_valid_cyc = -1;
    last_hs_cyc     = -1;
    busy_cnt        = 0;
  endtask

  task automatic start_req(input logic scan, input logic [3:0] sel);
    @(posedge clk); #1;
    ifc.scan_all        = scan;
    ifc.targetSelection = sel;
    ifc.req             = 1'b1;
    req_cyc             = cyc;
    @(posedge clk); #1;
    ifc.req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int k;
    k = 0;
    while (done_cnt == 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    n_vec++;
    if (done_cnt == 0) begin
      n_err++;
      $display("FAIL %s_timeout: no done after %0d cycles, required done", name, bound);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_frame(input string name);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s_len: got %0d bytes, required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s_byte%0d: got %h, required %h", name, i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic load_slot3();
    mem_x[3] = 8'h11;
    mem_y[3] = 8'h22;
    mem_z[3] = 8'h33;
    mem_t[3] = 8'h44;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({ifc.tx_data, ifc.tx_valid, ifc.busy, ifc.done, ifc.rd_addr} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: data=%h valid=%b busy=%b done=%b addr=%h, required all 0",
               ifc.tx_data, ifc.tx_valid, ifc.busy, ifc.done, ifc.rd_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (ifc.busy !== 1'b0 || ifc.tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: busy=%b valid=%b, required 0 0", ifc.busy, ifc.tx_valid);
    end
  endtask

  task automatic test_single_valid();
    ready_mode = 0;
    load_slot3();
    ifc.target_valid = 16'h0008 | 16'($urandom());
    build_exp(1'b0, 4'd3);
    clear_mon();
    start_req(1'b0, 4'd3);
    wait_done("single_valid", 200);
    check_frame("single_valid");
    n_vec++;
    if (obs_q.size() != 6 || obs_q[0] !== 8'hA3 || obs_q[5] !== 8'hE7) begin
      n_err++;
      $display("FAIL single_valid_literal: got %0d bytes, required A3..E7 six bytes", obs_q.size());
    end
    n_vec++;
    if (first_valid_cyc - req_cyc != 2) begin
      n_err++;
      $display("FAIL latency: got %0d cycles, required 2", first_valid_cyc - req_cyc);
    end
    n_vec++;
    if (done_cyc - last_hs_cyc != 1 || done_cnt != 1) begin
      n_err++;
      $display("FAIL single_done: gap=%0d count=%0d, required gap 1 count 1",
               done_cyc - last_hs_cyc, done_cnt);
    end
  endtask

  task automatic test_single_empty();
    ready_mode = 0;
    ifc.target_valid = 16'hFFFF & ~16'h0020;
    build_exp(1'b0, 4'd5);
    clear_mon();
    start_req(1'b0, 4'd5);
    wait_done("single_empty", 200);
    check_frame("single_empty");
    n_vec++;
    if (obs_q.size() != 2 || obs_q[0] !== 8'hE5 || obs_q[1] !== 8'hE5) begin
      n_err++;
      $display("FAIL empty_literal: got %0d bytes, required E5 E5", obs_q.size());
    end
    n_vec++;
    if (done_cyc - req_cyc != 4 || done_cnt != 1) begin
      n_err++;
      $display("FAIL empty_busy_span: got %0d cycles count %0d, required 4 count 1",
               done_cyc - req_cyc, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    mem_x[0] = 8'($urandom());
    mem_y[0] = 8'($urandom());
    mem_z[0] = 8'($urandom());
    mem_t[0] = 8'($urandom());
    ifc.target_valid = 16'h0001;
    build_exp(1'b0, 4'd0);
    clear_mon();
    ready_mode = 1;
    start_req(1'b0, 4'd0);
    wait_done("backpressure", 400);
    check_frame("backpressure");
    ready_mode = 0;
  endtask

  task automatic test_scan();
    ready_mode = 0;
    for (int i = 0; i < 16; i++) begin
      mem_x[i] = 8'($urandom());
      mem_y[i] = 8'($urandom());
      mem_z[i] = 8'($urandom());
      mem_t[i] = 8'($urandom());
    end
    ifc.target_valid = 16'h8004;
    build_exp(1'b1, 4'd7);
    clear_mon();
    start_req(1'b1, 4'd7);
    wait_done("scan_2_15", 400);
    check_frame("scan_2_15");
    n_vec++;
    if (obs_q.size() != 12 || obs_q[0] !== 8'hA2 || obs_q[6] !== 8'hAF || done_cnt != 1) begin
      n_err++;
      $display("FAIL scan_frames: got %0d bytes done=%0d, required 12 bytes A2/AF done=1",
               obs_q.size(), done_cnt);
    end

    ifc.target_valid = 16'h0000;
    clear_mon();
    start_req(1'b1, 4'd0);
    wait_done("scan_empty", 200);
    n_vec++;
    if (obs_q.size() != 0 || busy_cnt != 32 || done_cnt != 1) begin
      n_err++;
      $display("FAIL scan_empty: bytes=%0d busy=%0d done=%0d, required 0 32 1",
               obs_q.size(), busy_cnt, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    ready_mode = 0;
    ifc.target_valid = 16'hFFFF;
    build_exp(1'b1, 4'd0);
    clear_mon();
    start_req(1'b1, 4'd0);
    wait_done("back_to_back", 400);
    check_frame("back_to_back");
    n_vec++;
    if (busy_cnt != 16 * 8) begin
      n_err++;
      $display("FAIL back_to_back_busy: got %0d cycles, required %0d", busy_cnt, 16 * 8);
    end
  endtask

  task automatic test_snapshot();
    int k;
    ready_mode = 0;
    load_slot3();
    ifc.target_valid = 16'h0008;
    build_exp(1'b0, 4'd3);
    clear_mon();
    start_req(1'b0, 4'd3);
    k = 0;
    while (obs_q.size() < 2 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1 mem_x[3] = 8'hFF;
    wait_done("snapshot", 200);
    check_frame("snapshot");
    n_vec++;
    if (obs_q.size() < 2 || obs_q[1] !== 8'h11) begin
      n_err++;
      $display("FAIL snapshot_x: got %0d bytes, required X byte 11", obs_q.size());
    end
    mem_x[3] = 8'h11;
  endtask

  task automatic test_reset_mid();
    int k;
    ready_mode = 0;
    load_slot3();
    ifc.target_valid = 16'h0008;
    clear_mon();
    start_req(1'b0, 4'd3);
    k = 0;
    while (obs_q.size() < 3 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (ifc.tx_valid !== 1'b0 || ifc.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: valid=%b busy=%b, required 0 0", ifc.tx_valid, ifc.busy);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (done_cnt != 0 || obs_q.size() != 3 || ifc.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abort: done=%0d bytes=%0d busy=%b, required 0 3 0",
               done_cnt, obs_q.size(), ifc.busy);
    end
    build_exp(1'b0, 4'd3);
    clear_mon();
    start_req(1'b0, 4'd3);
    wait_done("after_reset", 200);
    check_frame("after_reset");
  endtask

  task automatic test_random();
    logic scan;
    logic [3:0] sel;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 16; i++) begin
        mem_x[i] = 8'($urandom());
        mem_y[i] = 8'($urandom());
        mem_z[i] = 8'($urandom());
        mem_t[i] = 8'($urandom());
      end
      ifc.target_valid = 16'($urandom());
      scan = 1'($urandom_range(0, 1));
      sel  = 4'($urandom_range(0, 15));
      ready_mode = 2;
      build_exp(scan, sel);
      clear_mon();
      start_req(scan, sel);
      wait_done("random", 2000);
      check_frame("random");
      n_vec++;
      if (done_cnt != 1) begin
        n_err++;
        $display("FAIL random_done: got %0d pulses, required 1", done_cnt);
      end
    end
    ready_mode = 0;
  endtask

  initial begin
    ifc.req             = 1'b0;
    ifc.scan_all        = 1'b0;
    ifc.targetSelection = 4'd0;
    ifc.target_valid    = 16'h0;
    for (int i = 0; i < 16; i++) begin
      mem_x[i] = 8'h0;
      mem_y[i] = 8'h0;
      mem_z[i] = 8'h0;
      mem_t[i] = 8'h0;
    end
    clear_mon();
    test_reset();
    test_single_valid();
    test_single_empty();
    test_backpressure();
    test_scan();
    test_back_to_back();
    test_snapshot();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/telem_target_reader.md
TELEM_TARGET_READER -- requirements
Module: telem_target_reader

Interface
REQ-001 Parameter HDR_OK, default 4'hA, is the upper header nibble for a valid target frame.
REQ-002 Parameter HDR_EMPTY, default 4'hE, is the upper header nibble for an empty-slot frame.
REQ-003 Clock is clk, reset is rst; one clock; rst SHALL be asynchronous and active-high.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge
- rst  in  1  async active-high reset
- req  in  1  start readout; sampled only in IDLE
- scan_all  in  1  1 = stream all valid slots 0..15; 0 = single slot
- targetSelection  in  4  slot index for single mode
- target_valid  in  16  per-slot occupied flags from the target register file
- rd_addr  out  4  slot index driven to the target register file
- rd_x, rd_y, rd_z, rd_t  in  8 each  combinational read data for slot rd_addr
- tx_data  out  8  outbound byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts byte when tx_valid & tx_ready
- busy  out  1  frame or scan in progress
- done  out  1  one-cycle pulse at end of request

Function
REQ-005 FSM states: IDLE, LATCH, HDR, BX, BY, BZ, BT, CSUM, NEXT.
REQ-006 IDLE: on req=1, load rd_addr <= (scan_all ? 0 : targetSelection), latch the mode, and go to LATCH; req in any other state SHALL be ignored.
REQ-007 LATCH (one cycle): snapshot rd_x/rd_y/rd_z/rd_t and target_valid[rd_addr] into internal registers; later table writes SHALL NOT alter the frame in flight.
REQ-008 Single mode, valid slot: the frame SHALL be 6 bytes: {HDR_OK,idx}, X, Y, Z, T, CSUM. CSUM = XOR of the preceding 5 bytes.
REQ-009 Single mode, empty slot: the frame SHALL be 2 bytes: {HDR_EMPTY,idx}, CSUM = header byte.
REQ-010 Scan mode: empty slots SHALL be skipped and emit no bytes. Each valid slot emits a 6-byte frame. Slots are processed in ascending index order.
REQ-011 NEXT (scan mode): if rd_addr==15, finish; else rd_addr <= rd_addr+1 and go to LATCH. A skipped slot costs exactly LATCH+NEXT (2 cycles). The index SHALL NOT wrap.
REQ-012 Latency: tx_valid SHALL rise on the 2nd rising edge after the req-sampling edge (IDLE->LATCH->HDR).
REQ-013 Handshake: a byte advances only on a clock edge with tx_valid & tx_ready. While tx_valid=1 & tx_ready=0, tx_data SHALL hold stable and tx_valid SHALL stay high.
REQ-014 tx_ready high with tx_valid low SHALL have no effect. Back-to-back bytes at one per cycle SHALL be supported when tx_ready is held high.
REQ-015 tx_valid SHALL be 0 in IDLE, LATCH and NEXT.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 done SHALL pulse for one cycle on the cycle the FSM re-enters IDLE, which is one of:
- the final CSUM handshake;
- in scan mode, NEXT at index 15;
- a scan with zero valid slots, after 16 LATCH/NEXT pairs.
REQ-018 Checksum is an 8-bit XOR. It resets at each HDR and has no carry or width growth.

Reset
REQ-019 rst assertion SHALL force IDLE immediately, independent of clk, and clear all outputs:
- tx_data=0, tx_valid=0, busy=0, done=0, rd_addr=0;
- snapshot and checksum registers=0.
REQ-020 rst mid-frame SHALL abort the frame with no further bytes. After release, a new req is required.
REQ-021 Release of rst SHALL NOT by itself start a readout, even if req is high. req is sampled on the first edge after release.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Single valid: slot 3 = X 8'h11, Y 8'h22, Z 8'h33, T 8'h44, tx_ready=1 -> bytes A3,11,22,33,44,E7; done one cycle after E7.
- Single empty: targetSelection=5, target_valid[5]=0 -> bytes E5,E5; done pulses; total busy 4 cycles.
- Backpressure: slot 0 valid, tx_ready toggled 0/1 every cycle -> each byte held stable while stalled; sequence identical to the unstalled case.
- Scan: valid slots {2,15} only, tx_ready=1 -> 12 bytes, A2 frame then AF frame, one done. Scan with target_valid=0 -> zero bytes, done after 32 cycles.
- Snapshot: rewrite slot 3 X to 8'hFF during BY -> transmitted X stays 8'h11.
- Reset mid-frame: rst asserted during BZ -> tx_valid/busy drop without a clock edge; no done; next req yields a complete frame.
